// File: rtl/led_frame_scanner.sv
// led_frame_scanner: double-buffered 8x8 LED frame store with row-multiplexed scan output
// Ports: clkh/reset (async, active-high); we/waddr/wdata write a row into the back bank;
//        swap_req asks for a front/back swap at the next frame boundary, swap_ack pulses when applied;
//        frame_start pulses on the first lit cycle of row 0; row is one-hot active-low, col active-high.
// Optional: define LED_SCAN_BLANK_EN to insert BLANK all-off cycles after every row.
module led_frame_scanner #(
    parameter int DWELL = 6250,
    parameter int BLANK = 16
) (
    input  logic       clkh,
    input  logic       reset,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic       swap_req,
    output logic       swap_ack,
    output logic       frame_start,
    output logic [7:0] row,
    output logic [7:0] col
);
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_BLANK} state_t;
    localparam logic [12:0] DW_LAST = 13'(DWELL - 1);

    if (DWELL < 2 || DWELL > 8191) begin : g_bad_dwell
        $error("DWELL out of range");
    end
    if (BLANK < 1 || BLANK > 255) begin : g_bad_blank
        $error("BLANK out of range");
    end

    state_t st, st_n;
    logic [2:0] idx, idx_n;
    logic [12:0] cnt, cnt_n;
    logic front, front_n, pending, pending_n;
    logic lit_end, adv, swap, enter0;
    logic [7:0] row_n, col_n, disp;
    logic [7:0] bank [2][8];
`ifdef LED_SCAN_BLANK_EN
    localparam logic [7:0] BL_LAST = 8'(BLANK - 1);
    logic [7:0] bcnt, bcnt_n;
    logic blank_end;
    assign blank_end = st == ST_BLANK && bcnt == BL_LAST;
    assign adv = blank_end;
`else
    assign adv = lit_end;
`endif
    assign lit_end = st == ST_SCAN && cnt == DW_LAST;
    assign swap = adv && idx == 3'd7 && (pending || swap_req);
    assign enter0 = st == ST_IDLE || (adv && idx == 3'd7);
    assign front_n = front ^ swap;
    assign pending_n = swap ? 1'b0 : pending | swap_req;

    always_comb begin
        st_n = st;
        idx_n = adv ? idx + 3'd1 : idx;
        cnt_n = st == ST_SCAN ? (lit_end ? 13'd0 : cnt + 13'd1) : 13'd0;
        if (st == ST_IDLE) st_n = ST_SCAN;
`ifdef LED_SCAN_BLANK_EN
        bcnt_n = st == ST_BLANK ? (blank_end ? 8'd0 : bcnt + 8'd1) : 8'd0;
        if (lit_end) st_n = ST_BLANK;
        if (blank_end) st_n = ST_SCAN;
`endif
        disp = bank[front_n][idx_n];
        // a write on the swap edge lands in the bank that becomes visible right now
        row_n = st_n == ST_SCAN ? ~(8'b1 << idx_n) : 8'hFF;
        col_n = st_n != ST_SCAN ? 8'h00 : (swap && we && waddr == idx_n) ? wdata : disp;
    end

    always_ff @(posedge clkh or posedge reset) begin
        if (reset) begin
            st <= ST_IDLE;
            idx <= 3'd0;
            cnt <= 13'd0;
            front <= 1'b0;
            pending <= 1'b0;
            swap_ack <= 1'b0;
            frame_start <= 1'b0;
            row <= 8'hFF;
            col <= 8'h00;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    bank[b][r] <= 8'h00;
        end else begin
            st <= st_n;
            idx <= idx_n;
            cnt <= cnt_n;
            front <= front_n;
            pending <= pending_n;
            swap_ack <= swap;
            frame_start <= enter0;
            row <= row_n;
            col <= col_n;
            if (we) bank[~front][waddr] <= wdata;
        end
    end

`ifdef LED_SCAN_BLANK_EN
    always_ff @(posedge clkh or posedge reset) begin
        if (reset) bcnt <= 8'd0;
        else bcnt <= bcnt_n;
    end
`endif
endmodule

// File: tb/tb_led_frame_scanner.sv
// tb_led_frame_scanner: frame-arithmetic reference model plus directed scenarios for led_frame_scanner
module tb_led_frame_scanner;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
`ifdef LED_SCAN_BLANK_EN
    localparam int ROWP = DWELL + BLANK;
`else
    localparam int ROWP = DWELL;
`endif
    localparam int FP = 8 * ROWP;

    logic clkh = 0, reset = 0, we = 0, swap_req = 0;
    logic [2:0] waddr = 0;
    logic [7:0] wdata = 0;
    logic swap_ack, frame_start;
    logic [7:0] row, col;

    led_frame_scanner #(.DWELL(DWELL), .BLANK(BLANK)) dut (
        .clkh(clkh), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
        .row(row), .col(col)
    );

    always #5 clkh = ~clkh;

    int errors = 0, checks = 0;

    // model: t counts cycles since the first edge after reset; everything follows from t
    logic [7:0] mbank [2][8];
    logic mfront = 0, mpend = 0, started = 0, mack = 0;
    int t = 0;

    always @(posedge clkh or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < 8; r++)
                    mbank[b][r] = 8'h00;
            mfront = 0;
            mpend = 0;
            started = 0;
            mack = 0;
            t = 0;
        end else begin
            mack = 0;
            if (started) t++;
            else started = 1;
            if (we) mbank[int'(!mfront)][waddr] = wdata;
            if (swap_req) mpend = 1;
            if (t > 0 && t % FP == 0 && mpend) begin
                mfront = !mfront;
                mpend = 0;
                mack = 1;
            end
        end
    end

    function automatic logic exp_lit();
        return started && (t % ROWP) < DWELL;
    endfunction

    function automatic logic [7:0] exp_row();
        logic [7:0] one = 8'h01;
        return exp_lit() ? ~(one << ((t % FP) / ROWP)) : 8'hFF;
    endfunction

    function automatic logic [7:0] exp_col();
        return exp_lit() ? mbank[int'(mfront)][(t % FP) / ROWP] : 8'h00;
    endfunction

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0d actual=%h required=%h", n, t, a, e);
        end
    endtask

    always @(negedge clkh) begin
        chk("m_row", row, exp_row());
        chk("m_col", col, exp_col());
        chk("m_fs", {7'd0, frame_start}, {7'd0, started && t % FP == 0});
        chk("m_ack", {7'd0, swap_ack}, {7'd0, mack});
    end

    task automatic wait_pos(input int p);
        int n = 0;
        while (!(started && t % FP == p) && n < 4 * FP) begin
            @(negedge clkh);
            n++;
        end
        if (n >= 4 * FP) begin
            checks++;
            errors++;
            $display("FAIL wait_pos actual=timeout required=pos %0d", p);
        end
    endtask

    int acks;

    initial begin
        #1 reset = 1;
        repeat (3) @(negedge clkh);
        chk("rst_row", row, 8'hFF);
        chk("rst_col", col, 8'h00);
        chk("rst_fs", {7'd0, frame_start}, 8'h00);
        reset = 0;
        @(negedge clkh);
        chk("first_row", row, 8'hFE);
        chk("first_fs", {7'd0, frame_start}, 8'h01);
        chk("first_col", col, 8'h00);
`ifdef LED_SCAN_BLANK_EN
        repeat (DWELL) @(negedge clkh);
        chk("blank_row", row, 8'hFF);
        chk("blank_col", col, 8'h00);
        repeat (ROWP - DWELL) @(negedge clkh);
`else
        repeat (ROWP) @(negedge clkh);
`endif
        chk("row1", row, 8'hFD);
        repeat (FP - ROWP) @(negedge clkh);
        chk("fs_frame2", {7'd0, frame_start}, 8'h01);
        chk("row0_frame2", row, 8'hFE);
        repeat (7 * ROWP) @(negedge clkh);
        chk("row7", row, 8'h7F);

        for (int i = 0; i < 8; i++) begin
            we = 1;
            waddr = 3'(i);
            wdata = 8'h01 << i;
            @(negedge clkh);
        end
        we = 0;
        wait_pos(3 * ROWP);
        swap_req = 1;
        @(negedge clkh);
        swap_req = 0;
        chk("col_before_swap", col, 8'h00);
        wait_pos(0);
        chk("ack_with_fs", {7'd0, swap_ack}, 8'h01);
        chk("col_row0_swapped", col, 8'h01);
        repeat (3 * ROWP) @(negedge clkh);
        chk("col_row3_swapped", col, 8'h08);

        for (int i = 0; i < 8; i++) begin
            we = 1;
            waddr = 3'(i);
            wdata = 8'hA0 | 8'(i);
            @(negedge clkh);
        end
        we = 0;
        wait_pos(FP - 1);
        swap_req = 1;
        we = 1;
        waddr = 0;
        wdata = 8'h5A;
        @(negedge clkh);
        swap_req = 0;
        we = 0;
        chk("edge_ack", {7'd0, swap_ack}, 8'h01);
        chk("edge_fs", {7'd0, frame_start}, 8'h01);
        chk("edge_write_col", col, 8'h5A);
        repeat (ROWP) @(negedge clkh);
        chk("edge_row1_col", col, 8'hA1);

        wait_pos(2);
        acks = 0;
        for (int k = 0; k < 2 * FP; k++) begin
            swap_req = (k == 0 || k == 8 || k == 18);
            @(negedge clkh);
            if (swap_ack) acks++;
        end
        swap_req = 0;
        chk("one_ack", 8'(acks), 8'd1);
        wait_pos(2 * ROWP);
        chk("one_toggle_col", col, 8'h04);

        wait_pos(5 * ROWP + 1);
        #2 reset = 1;
        #1;
        chk("async_row", row, 8'hFF);
        chk("async_col", col, 8'h00);
        repeat (3) @(negedge clkh);
        reset = 0;
        @(negedge clkh);
        chk("rst2_row", row, 8'hFE);
        chk("rst2_fs", {7'd0, frame_start}, 8'h01);
        chk("rst2_col", col, 8'h00);
        swap_req = 1;
        @(negedge clkh);
        swap_req = 0;
        wait_pos(3 * ROWP);
        wait_pos(0);
        chk("rst2_ack", {7'd0, swap_ack}, 8'h01);
        repeat (3 * ROWP) @(negedge clkh);
        chk("cleared_col", col, 8'h00);
        chk("cleared_row", row, 8'hF7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_frame_scanner.md
# led_frame_scanner

Scan controller and double-buffered frame store for the 8x8 LED dot matrix. Sits between pattern-generating logic and the matrix pins: requesters write rows into a back buffer, and the block multiplexes the front buffer onto `row`/`col` one row at a time. A requested buffer swap takes effect only at a frame boundary, so the display never shows a torn frame. Runs on the fast system clock `clkh`; `reset` is the debounced reset button.

## Interface
- `DWELL`, 6250: `clkh` cycles each row is lit. Legal range is 2..8191. At 50 MHz the default gives a 1 kHz frame rate.
- `BLANK`, 16: `clkh` cycles of all-off between rows. Used only when `LED_SCAN_BLANK_EN` is defined. Legal range is 1..255.
- `clkh`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `we`, input, 1: write strobe into the back buffer.
- `waddr`, input, 3: row index to write.
- `wdata`, input, 8: row pixel data. Bit *i* drives column *i*; 1 = lit.
- `swap_req`, input, 1: one-cycle pulse or level. Requests a front/back swap at the next frame boundary.
- `swap_ack`, output, 1: one-cycle pulse when the swap is applied.
- `frame_start`, output, 1: one-cycle pulse on the first lit cycle of row 0.
- `row`, output, 8: row select, one-hot active-low. `8'hFF` means all rows off.
- `col`, output, 8: column data, active-high.

## Operation
- Storage: two banks of 8 rows x 8 bits, all flops.
  - `front` is a 1-bit bank select.
  - Display reads bank `front`; writes always go to bank `~front`.
- Write: on a rising edge with `we=1`, `bank[~front][waddr] <= wdata`.
  - The bank select is the value of `front` before that edge.
  - A write on the swap edge lands in the old back bank, which becomes visible from that frame on.
- Swap request:
  - `swap_req=1` on any edge sets the sticky `pending` flag.
  - Further requests while `pending=1` are merged.
- Scan state machine, states SCAN and BLANK:
  - SCAN: `row = ~(8'b1 << idx)`; `col = bank[front][idx]`. The dwell counter counts 0..DWELL-1.
  - At count DWELL-1: go to BLANK if enabled, else advance `idx` and stay in SCAN.
  - BLANK: `row = 8'hFF`, `col = 8'h00` for BLANK cycles, then advance `idx` and go to SCAN.
  - `idx` wraps from 7 to 0.
- Frame boundary is the advance from `idx=7` to `idx=0`. On that edge:
  - If `pending=1`: toggle `front`, clear `pending`, and assert `swap_ack` together with `frame_start` in the first row-0 cycle.
  - If `swap_req` is asserted on the boundary edge itself, it counts for this boundary.
- `frame_start` pulses on every entry to row 0, including the first one after reset.

## Timing
- Reset values, held while `reset=1`:
  - `row = 8'hFF`, `col = 8'h00`, `swap_ack = 0`, `frame_start = 0`.
  - `front = 0`, `pending = 0`, `idx = 0`, counters 0, both banks all-zero.
- First rising edge after reset release:
  - Enter SCAN row 0: `row = 8'hFE`, `frame_start = 1`.
  - `col` shows bank 0 row 0, which is `8'h00`.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `col` changes only on the same edge that `row` changes.
  - A write can never alter what is currently displayed, because the front bank is never written.
- Row period is DWELL cycles, or DWELL+BLANK with blanking enabled. Frame period is 8 times the row period.
- Swap latency:
  - At most one frame period plus one cycle after `swap_req`.
  - Exactly one cycle if `swap_req` arrives on the boundary edge.
- `reset` mid-frame:
  - Immediately forces the reset values, including clearing both banks and `pending`.
  - Scanning restarts at row 0.

## Configuration
- `LED_SCAN_BLANK_EN` defined:
  - BLANK state and BLANK counter are compiled in.
  - Every row is followed by BLANK all-off cycles, to suppress ghosting.
  - The frame boundary moves to the end of row 7's blank period.
- `LED_SCAN_BLANK_EN` undefined:
  - BLANK logic and counter are absent and parameter BLANK is ignored.
  - Rows are back-to-back: `row` steps directly from `8'hFE` toward `8'h7F` with no all-off cycle.

## Test plan
- Reset then run (DWELL=4, no blanking):
  - `row` reads FE, FD, FB, F7, EF, DF, BF, 7F, each for 4 cycles, then FE again.
  - `frame_start` pulses every 32 cycles.
  - `col` is 00 throughout.
- Write rows 0..7 with `8'h01 << waddr`, then pulse `swap_req` mid-frame:
  - `col` stays 00 until the next `frame_start`.
  - `swap_ack` pulses with that `frame_start`.
  - From then on, `col` equals `8'h01 << idx`.
- `swap_req` asserted exactly on the row 7 to row 0 edge: swap is applied on that boundary, and `swap_ack` pulses 1 cycle later.
- Three `swap_req` pulses within one frame: only one `swap_ack`, and exactly one toggle of `front`.
- With `LED_SCAN_BLANK_EN`, DWELL=4, BLANK=2:
  - Each row is 4 cycles of lit value followed by 2 cycles of `row=FF`, `col=00`.
  - Frame period is 48 cycles.
- Assert `reset` during row 5 after loading data:
  - Outputs go to FF/00 asynchronously, before the next edge.
  - After release, both banks read 00 and `frame_start` pulses on the first edge.
